// File: rtl/rca_accum.sv
// Frame accumulator: sums valid/ready operand frames through a ripple-carry adder
// and reports sum, saturating carry-out count and saturating operand count.

module rca #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   always_comb begin
      logic carry;
      carry = cin;
      sum   = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end

endmodule

module rca_accum #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic [CNT_W-1:0] out_ovf_cnt,
   output logic [CNT_W-1:0] out_op_cnt
);

   typedef enum logic [1:0] {INIT, ACCUM, DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] ovf_cnt;
   logic [CNT_W-1:0] op_cnt;
   logic [WIDTH-1:0] add_sum;
   logic             add_cout;

   rca #(.WIDTH(WIDTH)) u_rca (
      .a    (acc),
      .b    (in_data),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Handshake inputs are only examined in the state where that handshake can occur,
   // so X on an idle control input never reaches the state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= INIT;
         acc       <= '0;
         ovf_cnt   <= '0;
         op_cnt    <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               state     <= ACCUM;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
            ACCUM: begin
               if (in_valid) begin
                  acc <= add_sum;
                  if (add_cout && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + CNT_ONE;
                  if (op_cnt != '1) op_cnt <= op_cnt + CNT_ONE;
                  if (in_last) begin
                     state     <= DONE;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  acc       <= '0;
                  ovf_cnt   <= '0;
                  op_cnt    <= '0;
                  state     <= ACCUM;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= INIT;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_sum     = acc;
   assign out_ovf_cnt = ovf_cnt;
   assign out_op_cnt  = op_cnt;

endmodule

// File: tb/tb_rca_accum.sv
// Directed bench for rca_accum: default instance plus a CNT_W=2 instance for saturation.

module tb_rca_accum;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic [31:0] in_data = '0;
   logic        out_ready = 1'b0;

   logic        in_ready, out_valid;
   logic [31:0] out_sum;
   logic [7:0]  out_ovf_cnt, out_op_cnt;

   logic        s_in_ready, s_out_valid;
   logic [31:0] s_out_sum;
   logic [1:0]  s_out_ovf_cnt, s_out_op_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rca_accum #(.WIDTH(32), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_ovf_cnt(out_ovf_cnt),
      .out_op_cnt(out_op_cnt)
   );

   rca_accum #(.WIDTH(32), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(s_out_valid),
      .out_ready(out_ready), .out_sum(s_out_sum), .out_ovf_cnt(s_out_ovf_cnt),
      .out_op_cnt(s_out_op_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one operand and hold it until the edge that accepts it; returns at edge+1.
   task automatic send(input logic [31:0] d, input logic l);
      int unsigned n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("send_timeout", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      // Reset release
      repeat (2) @(negedge clk);
      check("rst_in_ready", {31'b0, in_ready}, 32'd0);
      rst = 1'b0;
      #1;
      check("init_in_ready", {31'b0, in_ready}, 32'd0);
      check("init_out_valid", {31'b0, out_valid}, 32'd0);
      check("init_out_sum", out_sum, 32'd0);
      @(posedge clk);
      #1;
      check("accum_in_ready", {31'b0, in_ready}, 32'd1);
      check("accum_out_valid", {31'b0, out_valid}, 32'd0);

      // Frame 10, 20, 30
      out_ready = 1'b1;
      send(32'd10, 1'b0);
      send(32'd20, 1'b0);
      check("f1_mid_out_valid", {31'b0, out_valid}, 32'd0);
      send(32'd30, 1'b1);
      check("f1_out_valid", {31'b0, out_valid}, 32'd1);
      check("f1_in_ready", {31'b0, in_ready}, 32'd0);
      check("f1_sum", out_sum, 32'd60);
      check("f1_ovf", {24'b0, out_ovf_cnt}, 32'd0);
      check("f1_ops", {24'b0, out_op_cnt}, 32'd3);
      @(posedge clk);
      #1;
      check("f1_hs_out_valid", {31'b0, out_valid}, 32'd0);
      check("f1_hs_in_ready", {31'b0, in_ready}, 32'd1);
      check("f1_hs_sum_clear", out_sum, 32'd0);
      check("f1_hs_ops_clear", {24'b0, out_op_cnt}, 32'd0);

      // Overflow frame
      send(32'hFFFF_FFFF, 1'b0);
      send(32'h0000_0002, 1'b1);
      check("f2_out_valid", {31'b0, out_valid}, 32'd1);
      check("f2_sum", out_sum, 32'h0000_0001);
      check("f2_ovf", {24'b0, out_ovf_cnt}, 32'd1);
      check("f2_ops", {24'b0, out_op_cnt}, 32'd2);
      @(posedge clk);
      #1;
      check("f2_hs_out_valid", {31'b0, out_valid}, 32'd0);

      // Backpressure
      out_ready = 1'b0;
      send(32'd5, 1'b1);
      in_valid = 1'b1;
      in_data  = 32'd7;
      in_last  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check("bp_out_valid", {31'b0, out_valid}, 32'd1);
         check("bp_in_ready", {31'b0, in_ready}, 32'd0);
         check("bp_sum", out_sum, 32'd5);
         check("bp_ovf", {24'b0, out_ovf_cnt}, 32'd0);
         check("bp_ops", {24'b0, out_op_cnt}, 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_hs_out_valid", {31'b0, out_valid}, 32'd0);
      check("bp_hs_sum_clear", out_sum, 32'd0);
      check("bp_hs_in_ready", {31'b0, in_ready}, 32'd1);
      send(32'd7, 1'b1);
      check("f4_sum", out_sum, 32'd7);
      check("f4_ops", {24'b0, out_op_cnt}, 32'd1);
      @(posedge clk);
      #1;

      // Saturation: five all-ones operands
      for (int k = 0; k < 5; k++) send(32'hFFFF_FFFF, (k == 4) ? 1'b1 : 1'b0);
      check("sat_sum", s_out_sum, 32'hFFFF_FFFB);
      check("sat_ovf", {30'b0, s_out_ovf_cnt}, 32'd3);
      check("sat_ops", {30'b0, s_out_op_cnt}, 32'd3);
      check("sat_out_valid", {31'b0, s_out_valid}, 32'd1);
      check("wide_sum", out_sum, 32'hFFFF_FFFB);
      check("wide_ovf", {24'b0, out_ovf_cnt}, 32'd4);
      check("wide_ops", {24'b0, out_op_cnt}, 32'd5);
      @(posedge clk);
      #1;

      // Reset mid-frame
      send(32'd100, 1'b0);
      send(32'd200, 1'b0);
      check("mid_sum", out_sum, 32'd300);
      check("mid_ops", {24'b0, out_op_cnt}, 32'd2);
      rst = 1'b1;
      #1;
      check("arst_sum", out_sum, 32'd0);
      check("arst_ops", {24'b0, out_op_cnt}, 32'd0);
      check("arst_ovf", {24'b0, out_ovf_cnt}, 32'd0);
      check("arst_out_valid", {31'b0, out_valid}, 32'd0);
      check("arst_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rel_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      check("rel2_in_ready", {31'b0, in_ready}, 32'd1);
      send(32'd1, 1'b1);
      check("f6_sum", out_sum, 32'd1);
      check("f6_ops", {24'b0, out_op_cnt}, 32'd1);
      check("f6_ovf", {24'b0, out_ovf_cnt}, 32'd0);
      @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
